// File: rtl/ex_muldiv_unit_pkg.sv
// Shared op and state encodings for the EX-stage multiply/divide engine.
package ex_muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } md_state_t;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between EX and the multiply/divide engine.
interface ex_muldiv_unit_if
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic               start_i;
    md_op_t             op_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               div_zero_o;
    logic               busy_o;
    logic               stallreq_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, div_zero_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, div_zero_o, busy_o, stallreq_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU producing {HI,LO}, one bit per clock.
// Latency: ready_o after WIDTH+1 edges from acceptance; divide by zero after 1 edge.
// Backpressure: stallreq_o holds EX while start_i is up and no result is ready; DONE holds until start_i drops.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  md
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    md_op_t             op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   oper;
    logic               neg_res;
    logic               neg_rem;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     sum;
    logic               add_cin;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] final_res;

    assign md.stallreq_o = md.start_i & ~md.ready_o;

    // acc holds {HI,LO}: LO starts as multiplier/dividend, HI accumulates
    // partial product/remainder. One WIDTH+1 adder serves both add and trial subtract.
    always_comb begin
        mag1 = md.opdata1_i;
        mag2 = md.opdata2_i;
        if (md_is_signed(md.op_i) && md.opdata1_i[WIDTH-1]) mag1 = -md.opdata1_i;
        if (md_is_signed(md.op_i) && md.opdata2_i[WIDTH-1]) mag2 = -md.opdata2_i;

        hi = acc[2*WIDTH-1:WIDTH];
        lo = acc[WIDTH-1:0];

        if (state == S_DIV) begin
            add_a   = {hi, lo[WIDTH-1]};
            add_b   = ~{1'b0, oper};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi};
            add_b   = {1'b0, oper};
            add_cin = 1'b0;
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

        // Partial remainder is always below 2*divisor, so sum[WIDTH] is the borrow.
        if (state == S_DIV) begin
            acc_next = sum[WIDTH] ? {add_a[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                  : {sum[WIDTH-1:0],   lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = lo[0] ? {sum, lo[WIDTH-1:1]}
                             : {1'b0, hi, lo[WIDTH-1:1]};
        end

        quot = acc_next[WIDTH-1:0];
        rem  = acc_next[2*WIDTH-1:WIDTH];
        if (neg_res) quot = -acc_next[WIDTH-1:0];
        if (neg_rem) rem  = -acc_next[2*WIDTH-1:WIDTH];

        if (state == S_DIV) final_res = {rem, quot};
        else if (neg_res)   final_res = -acc_next;
        else                final_res = acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            op_q          <= MD_MULT;
            cnt           <= '0;
            acc           <= '0;
            oper          <= '0;
            neg_res       <= 1'b0;
            neg_rem       <= 1'b0;
            md.result_o   <= '0;
            md.ready_o    <= 1'b0;
            md.div_zero_o <= 1'b0;
            md.busy_o     <= 1'b0;
        end else if (md.annul_i) begin
            state      <= S_IDLE;
            md.ready_o <= 1'b0;
            md.busy_o  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (md.start_i) begin
                        op_q          <= md.op_i;
                        cnt           <= '0;
                        md.div_zero_o <= 1'b0;
                        neg_res <= md_is_signed(md.op_i) & (md.opdata1_i[WIDTH-1] ^ md.opdata2_i[WIDTH-1]);
                        neg_rem <= (md.op_i == MD_DIV) & md.opdata1_i[WIDTH-1];
                        if (md_is_div(md.op_i)) begin
                            oper <= mag2;
                            acc  <= {{WIDTH{1'b0}}, mag1};
                            if (md.opdata2_i == '0) begin
                                state         <= S_DONE;
                                md.result_o   <= '0;
                                md.div_zero_o <= 1'b1;
                                md.ready_o    <= 1'b1;
                            end else begin
                                state     <= S_DIV;
                                md.busy_o <= 1'b1;
                            end
                        end else begin
                            oper      <= mag1;
                            acc       <= {{WIDTH{1'b0}}, mag2};
                            state     <= S_MUL;
                            md.busy_o <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        md.result_o <= final_res;
                        md.ready_o  <= 1'b1;
                        md.busy_o   <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!md.start_i) begin
                        state      <= S_IDLE;
                        md.ready_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
